// File: rtl/vram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : vram_arbiter
// Purpose  : Shares one port of the framebuffer RAM between the VGA pixel
//            fetcher (high priority, fixed-latency reads) and the CPU
//            load/store path (req/ack handshake). One access is issued per
//            clock. A tag pipeline tracks who owns each read through the RAM
//            latency. A wait counter bounds how long the CPU can be starved.
// Ports    :
//   clk, rst_n        clock, asynchronous active-low reset
//   i_vga_req/addr    VGA read request and address
//   o_vga_gnt         VGA request accepted this cycle (combinational)
//   o_vga_rvalid/rdata  registered VGA read completion
//   i_cpu_req/we/addr/wdata  CPU transaction, held until o_cpu_ack
//   o_cpu_ack/rdata   registered one-cycle CPU completion (+ read data)
//   o_ram_addr/data/wren  registered RAM port controls
//   i_ram_q           RAM read data
// Revision : 1.0 - initial release
// ============================================================================
module vram_arbiter #(
   parameter int ADDR_W   = 18,
   parameter int WDATA_W  = 8,
   parameter int RDATA_W  = 32,
   parameter int RD_LAT   = 2,
   parameter int MAX_WAIT = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               i_vga_req,
   input  logic [ADDR_W-1:0]  i_vga_addr,
   output logic               o_vga_gnt,
   output logic               o_vga_rvalid,
   output logic [RDATA_W-1:0] o_vga_rdata,
   input  logic               i_cpu_req,
   input  logic               i_cpu_we,
   input  logic [ADDR_W-1:0]  i_cpu_addr,
   input  logic [WDATA_W-1:0] i_cpu_wdata,
   output logic               o_cpu_ack,
   output logic [RDATA_W-1:0] o_cpu_rdata,
   output logic [ADDR_W-1:0]  o_ram_addr,
   output logic [WDATA_W-1:0] o_ram_data,
   output logic               o_ram_wren,
   input  logic [RDATA_W-1:0] i_ram_q
);

   localparam logic [1:0] C_IDLE    = 2'd0;
   localparam logic [1:0] C_PEND    = 2'd1;
   localparam logic [1:0] C_RD_WAIT = 2'd2;

   localparam logic [7:0] c_MAX_WAIT = 8'(MAX_WAIT);

   logic [1:0]         r_state;
   logic [1:0]         w_state_nxt;
   logic [7:0]         r_wait_cnt;
   logic               w_cpu_pending;
   logic               w_starved;
   logic               w_vga_win;
   logic               w_cpu_win;
   logic               w_rd_grant;
   logic               w_cpu_rd_done;
   logic               w_vga_rd_done;

   // Tag pipeline: bit k describes the read granted k+1 cycles ago. The
   // output registers (rvalid/ack) form the final stage, giving RD_LAT+1
   // stages in total.
   logic [RD_LAT-1:0]  r_tag_v;
   logic [RD_LAT-1:0]  r_tag_cpu;

   logic               r_vga_rvalid;
   logic [RDATA_W-1:0] r_vga_rdata;
   logic               r_cpu_ack;
   logic [RDATA_W-1:0] r_cpu_rdata;
   logic [ADDR_W-1:0]  r_ram_addr;
   logic [WDATA_W-1:0] r_ram_data;
   logic               r_ram_wren;

   // ------------------------------------------------------------------------
   // CPU FSM: state register
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= C_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // ------------------------------------------------------------------------
   // CPU FSM: next state
   // ------------------------------------------------------------------------
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         C_IDLE, C_PEND: begin
            if (w_cpu_win) begin
               // Writes complete one cycle after the grant, so no wait state.
               w_state_nxt = i_cpu_we ? C_IDLE : C_RD_WAIT;
            end else begin
               w_state_nxt = w_cpu_pending ? C_PEND : C_IDLE;
            end
         end
         C_RD_WAIT: begin
            // Leave on the edge that raises the ack, so the ack cycle itself
            // is seen in C_IDLE with the request masked by o_cpu_ack.
            if (w_cpu_rd_done) begin
               w_state_nxt = C_IDLE;
            end
         end
         default: w_state_nxt = C_IDLE;
      endcase
   end

   // ------------------------------------------------------------------------
   // CPU FSM: outputs
   // ------------------------------------------------------------------------
   always_comb begin
      w_cpu_pending = 1'b0;
      if ((r_state == C_IDLE) || (r_state == C_PEND)) begin
         w_cpu_pending = i_cpu_req & ~r_cpu_ack;
      end
   end

   // ------------------------------------------------------------------------
   // Arbitration
   // ------------------------------------------------------------------------
   always_comb begin
      w_starved  = w_cpu_pending & (r_wait_cnt == c_MAX_WAIT);
      w_vga_win  = i_vga_req & ~w_starved;
      w_cpu_win  = w_cpu_pending & (w_starved | ~i_vga_req);
      w_rd_grant = w_vga_win | (w_cpu_win & ~i_cpu_we);
   end

   assign w_cpu_rd_done = r_tag_v[RD_LAT-1] &  r_tag_cpu[RD_LAT-1];
   assign w_vga_rd_done = r_tag_v[RD_LAT-1] & ~r_tag_cpu[RD_LAT-1];

   // ------------------------------------------------------------------------
   // Issue, tag tracking and completion
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wait_cnt   <= 8'd0;
         r_tag_v      <= '0;
         r_tag_cpu    <= '0;
         r_ram_addr   <= '0;
         r_ram_data   <= '0;
         r_ram_wren   <= 1'b0;
         r_vga_rvalid <= 1'b0;
         r_vga_rdata  <= '0;
         r_cpu_ack    <= 1'b0;
         r_cpu_rdata  <= '0;
      end else begin
         if (w_cpu_win) begin
            r_wait_cnt <= 8'd0;
         end else if (w_vga_win && w_cpu_pending && (r_wait_cnt != c_MAX_WAIT)) begin
            r_wait_cnt <= r_wait_cnt + 8'd1;
         end

         // Idle cycles leave address/data untouched; only wren drops.
         if (w_vga_win) begin
            r_ram_addr <= i_vga_addr;
         end else if (w_cpu_win) begin
            r_ram_addr <= i_cpu_addr;
            r_ram_data <= i_cpu_wdata;
         end
         r_ram_wren <= w_cpu_win & i_cpu_we;

         r_tag_v   <= (r_tag_v   << 1) | RD_LAT'(w_rd_grant);
         r_tag_cpu <= (r_tag_cpu << 1) | RD_LAT'(w_cpu_win);

         // i_ram_q is valid for the oldest tag in this cycle.
         r_vga_rvalid <= w_vga_rd_done;
         if (w_vga_rd_done) begin
            r_vga_rdata <= i_ram_q;
         end

         r_cpu_ack <= (w_cpu_win & i_cpu_we) | w_cpu_rd_done;
         if (w_cpu_rd_done) begin
            r_cpu_rdata <= i_ram_q;
         end
      end
   end

   // Gated so the grant also reads 0 while reset is held.
   assign o_vga_gnt    = w_vga_win & rst_n;
   assign o_vga_rvalid = r_vga_rvalid;
   assign o_vga_rdata  = r_vga_rdata;
   assign o_cpu_ack    = r_cpu_ack;
   assign o_cpu_rdata  = r_cpu_rdata;
   assign o_ram_addr   = r_ram_addr;
   assign o_ram_data   = r_ram_data;
   assign o_ram_wren   = r_ram_wren;

endmodule
`default_nettype wire
